// File: rtl/str_width_pack.sv
// Stream upsizer: packs RATIO narrow valid/ready beats into one registered wide beat.
// Optional packet framing (last/keep, partial words) is enabled by defining STR_PACK_LAST_EN.
module str_width_pack #(
  parameter int    IN_WIDTH = 16,
  parameter int    RATIO    = 4,
  parameter string SIM      = "FALSE",
  parameter string DEBUG    = "FALSE"
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [IN_WIDTH-1:0]          inp_str_data,
  input  logic                         inp_str_vld,
  output logic                         inp_str_rdy,
`ifdef STR_PACK_LAST_EN
  input  logic                         inp_str_last,
  output logic                         oup_str_last,
  output logic [RATIO-1:0]             oup_str_keep,
`endif
  output logic [IN_WIDTH*RATIO-1:0]    oup_str_data,
  output logic                         oup_str_vld,
  input  logic                         oup_str_rdy
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int ACC_WIDTH = IN_WIDTH * (RATIO - 1);
  localparam int CNT_WIDTH = $clog2(RATIO);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RATIO - 1);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [ACC_WIDTH-1:0] acc;
  logic                 closing;
  logic                 accept;
  logic                 close_acc;
  logic                 fill_acc;
  logic                 take;
  logic [OUT_WIDTH-1:0] packed_word;

  // Lanes below pos come from the accumulator, lane pos is the closing beat, lanes above are zero.
  function automatic logic [OUT_WIDTH-1:0] pack_word(
    input logic [ACC_WIDTH-1:0] acc_lanes,
    input logic [IN_WIDTH-1:0]  beat,
    input logic [CNT_WIDTH-1:0] pos
  );
    logic [OUT_WIDTH-1:0] word;
    word = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (CNT_WIDTH'(k) < pos) begin
        word[k*IN_WIDTH +: IN_WIDTH] = acc_lanes[k*IN_WIDTH +: IN_WIDTH];
      end else if (CNT_WIDTH'(k) == pos) begin
        word[k*IN_WIDTH +: IN_WIDTH] = beat;
      end
    end
    if (pos == CNT_LAST) begin
      word[OUT_WIDTH-1 -: IN_WIDTH] = beat;
    end
    return word;
  endfunction

`ifdef STR_PACK_LAST_EN
  function automatic logic [RATIO-1:0] keep_mask(input logic [CNT_WIDTH-1:0] pos);
    logic [RATIO-1:0] mask;
    for (int k = 0; k < RATIO; k++) begin
      mask[k] = (CNT_WIDTH'(k) <= pos);
    end
    return mask;
  endfunction
`endif

  always_comb begin
    closing     = (cnt == CNT_LAST);
`ifdef STR_PACK_LAST_EN
    closing     = closing | inp_str_last;
`endif
    // A closing beat may only enter when the output register is free or being drained.
    inp_str_rdy = !closing || !oup_str_vld || oup_str_rdy;
    accept      = inp_str_vld && inp_str_rdy;
    close_acc   = accept && closing;
    fill_acc    = accept && !closing;
    take        = oup_str_vld && oup_str_rdy;
    cnt_nxt     = cnt;
    if (close_acc) begin
      cnt_nxt = '0;
    end else if (fill_acc) begin
      cnt_nxt = cnt + 1'b1;
    end
    packed_word = pack_word(acc, inp_str_data, cnt);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc <= '0;
    end else if (fill_acc) begin
      for (int k = 0; k < RATIO - 1; k++) begin
        if (cnt == CNT_WIDTH'(k)) begin
          acc[k*IN_WIDTH +: IN_WIDTH] <= inp_str_data;
        end
      end
    end
  end

  // Output register stage: loads on a closing accept, otherwise drains on take.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      oup_str_vld  <= 1'b0;
      oup_str_data <= '0;
`ifdef STR_PACK_LAST_EN
      oup_str_last <= 1'b0;
      oup_str_keep <= '0;
`endif
    end else if (close_acc) begin
      oup_str_vld  <= 1'b1;
      oup_str_data <= packed_word;
`ifdef STR_PACK_LAST_EN
      oup_str_last <= inp_str_last;
      oup_str_keep <= keep_mask(cnt);
`endif
    end else if (take) begin
      oup_str_vld  <= 1'b0;
    end
  end

  if (SIM == "TRUE") begin : g_sim
    property p_inp_hold;
      @(posedge i_clk) disable iff (i_rst)
        (inp_str_vld && !inp_str_rdy) |=> (inp_str_vld && $stable(inp_str_data));
    endproperty
    a_inp_hold: assert property (p_inp_hold);
  end

  if (DEBUG == "TRUE") begin : g_dbg
    (* mark_debug = "true" *) logic [CNT_WIDTH-1:0] dbg_cnt;
    (* mark_debug = "true" *) logic                 dbg_close_acc;
    assign dbg_cnt       = cnt;
    assign dbg_close_acc = close_acc;
  end

endmodule

// File: tb/tb_str_width_pack.sv
// Bench for str_width_pack: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic and backpressure.
module tb_str_width_pack;
  localparam int IN_W  = 16;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;
`ifdef STR_PACK_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [IN_W-1:0]  inp_data = '0;
  logic             inp_vld = 1'b0;
  logic             inp_rdy;
  logic             inp_last = 1'b0;
  logic [OUT_W-1:0] oup_data;
  logic             oup_vld;
  logic             oup_rdy = 1'b0;
`ifdef STR_PACK_LAST_EN
  logic             oup_last;
  logic [RATIO-1:0] oup_keep;
`endif

  int checks = 0;
  int errors = 0;

  logic [IN_W-1:0]  cur_q[$];
  logic [OUT_W-1:0] held_q[$];
  logic             held_last_q[$];
  logic [RATIO-1:0] held_keep_q[$];
  logic [OUT_W-1:0] got_q[$];
  logic             got_last_q[$];
  logic [RATIO-1:0] got_keep_q[$];
  logic [OUT_W-1:0] last_data = '0;
  bit               dut_acc = 1'b0;

  always #5 clk = ~clk;

  str_width_pack #(.IN_WIDTH(IN_W), .RATIO(RATIO), .SIM("TRUE"), .DEBUG("FALSE")) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .inp_str_data (inp_data),
    .inp_str_vld  (inp_vld),
    .inp_str_rdy  (inp_rdy),
`ifdef STR_PACK_LAST_EN
    .inp_str_last (inp_last),
    .oup_str_last (oup_last),
    .oup_str_keep (oup_keep),
`endif
    .oup_str_data (oup_data),
    .oup_str_vld  (oup_vld),
    .oup_str_rdy  (oup_rdy)
  );

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats collect into a list; a word forms when RATIO beats (or a last beat)
  // arrive and is held until the consumer takes it.
  always @(negedge clk) begin
    logic             exp_vld;
    logic             model_last;
    logic             closing;
    logic             exp_rdy;
    logic [OUT_W-1:0] w;
    if (rst) begin
      chk("rst_vld", oup_vld, '0);
      chk("rst_data", oup_data, '0);
`ifdef STR_PACK_LAST_EN
      chk("rst_last", oup_last, '0);
      chk("rst_keep", oup_keep, '0);
`endif
      cur_q.delete();
      held_q.delete();
      held_last_q.delete();
      held_keep_q.delete();
      last_data = '0;
      dut_acc   = 1'b0;
    end else begin
      exp_vld    = (held_q.size() != 0);
      model_last = LAST_EN && inp_last;
      closing    = (cur_q.size() == RATIO - 1) || model_last;
      exp_rdy    = !closing || !exp_vld || oup_rdy;
      chk("oup_vld", oup_vld, exp_vld);
      if (exp_vld) begin
        chk("oup_data", oup_data, held_q[0]);
`ifdef STR_PACK_LAST_EN
        chk("oup_last", oup_last, held_last_q[0]);
        chk("oup_keep", oup_keep, held_keep_q[0]);
`endif
      end else begin
        chk("oup_data_hold", oup_data, last_data);
      end
      chk("inp_rdy", inp_rdy, exp_rdy);
      dut_acc = inp_vld && inp_rdy;
      if (exp_vld && oup_rdy) begin
        got_q.push_back(held_q.pop_front());
        got_last_q.push_back(held_last_q.pop_front());
        got_keep_q.push_back(held_keep_q.pop_front());
      end
      if (inp_vld && exp_rdy) begin
        cur_q.push_back(inp_data);
        if (cur_q.size() == RATIO || model_last) begin
          w = '0;
          for (int k = 0; k < cur_q.size(); k++) w[k*IN_W +: IN_W] = cur_q[k];
          held_q.push_back(w);
          held_last_q.push_back(model_last);
          held_keep_q.push_back(RATIO'((1 << cur_q.size()) - 1));
          last_data = w;
          cur_q.delete();
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IN_W-1:0] d, input logic l);
    int n;
    n        = 0;
    inp_vld  = 1'b1;
    inp_data = d;
    inp_last = l;
    @(negedge clk);
    while (!inp_rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("send_accept", inp_rdy, 1);
    @(posedge clk);
    #1;
    inp_vld  = 1'b0;
    inp_last = 1'b0;
  endtask

  task automatic clear_got();
    got_q.delete();
    got_last_q.delete();
    got_keep_q.delete();
  endtask

  initial begin
    step(2);
    rst = 1'b0;

    // Back-to-back streaming
    clear_got();
    oup_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) send(IN_W'(i), 1'b0);
    step(3);
    chk("t1_count", OUT_W'(got_q.size()), 2);
    if (got_q.size() >= 2) begin
      chk("t1_word1", got_q[0], 64'h0004_0003_0002_0001);
      chk("t1_word2", got_q[1], 64'h0008_0007_0006_0005);
    end

    // Backpressure with a stalled closing beat
    clear_got();
    oup_rdy = 1'b0;
    for (int i = 1; i <= 7; i++) send(IN_W'(16'h0010 + i), 1'b0);
    inp_vld  = 1'b1;
    inp_data = 16'h0018;
    repeat (3) begin
      @(negedge clk);
      chk("t2_stall_rdy", inp_rdy, 0);
      chk("t2_held_word", oup_data, 64'h0014_0013_0012_0011);
    end
    @(posedge clk);
    #1;
    oup_rdy = 1'b1;
    @(negedge clk);
    chk("t2_release_rdy", inp_rdy, 1);
    @(posedge clk);
    #1;
    inp_vld = 1'b0;
    @(negedge clk);
    chk("t2_no_bubble_vld", oup_vld, 1);
    chk("t2_word2", oup_data, 64'h0018_0017_0016_0015);
    step(2);
    chk("t2_count", OUT_W'(got_q.size()), 2);

    // Output take and closing beat in the same cycle
    clear_got();
    oup_rdy = 1'b0;
    for (int i = 1; i <= 7; i++) send(IN_W'(16'h0020 + i), 1'b0);
    inp_vld  = 1'b1;
    inp_data = 16'h0028;
    oup_rdy  = 1'b1;
    @(negedge clk);
    chk("t3_rdy", inp_rdy, 1);
    chk("t3_word1", oup_data, 64'h0024_0023_0022_0021);
    @(posedge clk);
    #1;
    inp_vld = 1'b0;
    @(negedge clk);
    chk("t3_vld", oup_vld, 1);
    chk("t3_word2", oup_data, 64'h0028_0027_0026_0025);
    step(2);

    // Reset in the middle of a word while a word is held
    oup_rdy = 1'b0;
    for (int i = 1; i <= 6; i++) send(IN_W'(16'h0030 + i), 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t4_async_vld", oup_vld, 0);
    chk("t4_async_data", oup_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_got();
    oup_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send(IN_W'(16'h000A + i), 1'b0);
    step(3);
    chk("t4_count", OUT_W'(got_q.size()), 1);
    if (got_q.size() >= 1) chk("t4_word", got_q[0], 64'h000D_000C_000B_000A);

`ifdef STR_PACK_LAST_EN
    // Partial words closed by last
    clear_got();
    send(16'h0011, 1'b0);
    send(16'h0022, 1'b0);
    send(16'h0033, 1'b1);
    send(16'h0055, 1'b1);
    step(3);
    chk("t5_count", OUT_W'(got_q.size()), 2);
    if (got_q.size() >= 2) begin
      chk("t5_word", got_q[0], 64'h0000_0033_0022_0011);
      chk("t5_keep", got_keep_q[0], 4'b0111);
      chk("t5_last", got_last_q[0], 1);
      chk("t6_word", got_q[1], 64'h0000_0000_0000_0055);
      chk("t6_keep", got_keep_q[1], 4'b0001);
      chk("t6_last", got_last_q[1], 1);
    end
`endif

    // Randomized traffic with protocol-respecting source
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!(inp_vld && !dut_acc)) begin
        inp_vld  = ($urandom_range(0, 3) != 0);
        inp_data = IN_W'($urandom);
        inp_last = ($urandom_range(0, 5) == 0);
      end
      if (i < 1000) oup_rdy = ($urandom_range(0, 7) != 0);
      else          oup_rdy = ($urandom_range(0, 1) != 0);
    end
    @(posedge clk);
    #1;
    inp_vld  = 1'b0;
    inp_last = 1'b0;
    oup_rdy  = 1'b1;
    step(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
